// File: rtl/alu_z_capture.sv
// Z register stage after the ALU: waits a per-opcode settle time, captures the 64-bit
// result, and serves ZLO/ZHI onto the bus. Optional flags via `ZREG_FLAGS_EN.
module alu_z_capture #(
    parameter int FAST_CYCLES = 1,
    parameter int SLOW_CYCLES = 4,
    parameter int CW          = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [4:0]  op_select,
    input  logic [63:0] alu_result,
    input  logic        rd_lo,
    input  logic        rd_hi,
    output logic        busy,
    output logic        z_valid,
    output logic [31:0] bus_out,
    output logic        bus_en
`ifdef ZREG_FLAGS_EN
    ,
    output logic        flag_z,
    output logic        flag_n
`endif
);

    localparam logic [4:0]    OP_MUL   = 5'b01111;
    localparam logic [4:0]    OP_DIV   = 5'b10000;
    localparam logic [CW-1:0] FAST_CNT = CW'(FAST_CYCLES);
    localparam logic [CW-1:0] SLOW_CNT = CW'(SLOW_CYCLES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        VALID  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [63:0]   z_q, z_d;
    logic          lo_done_q, lo_done_d;
    logic          hi_done_q, hi_done_d;
    logic          capture;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        z_d       = z_q;
        lo_done_d = lo_done_q;
        hi_done_d = hi_done_q;
        capture   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d   = (op_select == OP_MUL || op_select == OP_DIV) ? SLOW_CNT : FAST_CNT;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == CNT_ONE) begin
                    capture   = 1'b1;
                    z_d       = alu_result;
                    lo_done_d = 1'b0;
                    hi_done_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = VALID;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            VALID: begin
                // A new start abandons whatever half has not been read yet.
                if (start) begin
                    cnt_d   = (op_select == OP_MUL || op_select == OP_DIV) ? SLOW_CNT : FAST_CNT;
                    state_d = SETTLE;
                end else begin
                    if (rd_lo)      lo_done_d = 1'b1;
                    else if (rd_hi) hi_done_d = 1'b1;
                    if (lo_done_d && hi_done_d) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            z_q       <= '0;
            lo_done_q <= 1'b0;
            hi_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            z_q       <= z_d;
            lo_done_q <= lo_done_d;
            hi_done_q <= hi_done_d;
        end
    end

    always_comb begin
        busy    = (state_q == SETTLE);
        z_valid = (state_q == VALID);
        bus_out = '0;
        bus_en  = 1'b0;
        if (state_q == VALID) begin
            if (rd_lo) begin
                bus_out = z_q[31:0];
                bus_en  = 1'b1;
            end else if (rd_hi) begin
                bus_out = z_q[63:32];
                bus_en  = 1'b1;
            end
        end
    end

`ifdef ZREG_FLAGS_EN
    // The latched opcode is only needed to choose the flag rules at capture time.
    logic [4:0] op_q, op_d;
    logic       flag_z_q, flag_z_d;
    logic       flag_n_q, flag_n_d;

    always_comb begin
        op_d     = op_q;
        flag_z_d = flag_z_q;
        flag_n_d = flag_n_q;
        if (start && (state_q == IDLE || state_q == VALID)) op_d = op_select;
        if (capture) begin
            if (op_q == OP_MUL) begin
                flag_z_d = (alu_result == 64'd0);
                flag_n_d = alu_result[63];
            end else if (op_q == OP_DIV) begin
                flag_z_d = (alu_result == 64'd0);
                flag_n_d = alu_result[31];
            end else begin
                flag_z_d = (alu_result[31:0] == 32'd0);
                flag_n_d = alu_result[31];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= '0;
            flag_z_q <= 1'b0;
            flag_n_q <= 1'b0;
        end else begin
            op_q     <= op_d;
            flag_z_q <= flag_z_d;
            flag_n_q <= flag_n_d;
        end
    end

    assign flag_z = flag_z_q;
    assign flag_n = flag_n_q;
`endif

endmodule

// File: tb/tb_alu_z_capture.sv
// Scoreboard bench for alu_z_capture: expected captures are queued at launch and
// retired when z_valid rises; bus reads are checked against the retired entry.
module tb_alu_z_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  op_select;
    logic [63:0] alu_result;
    logic        rd_lo, rd_hi;
    logic        busy, z_valid, bus_en;
    logic [31:0] bus_out;
`ifdef ZREG_FLAGS_EN
    logic        flag_z, flag_n;
`endif

    always #5 clk = ~clk;

    alu_z_capture dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op_select  (op_select),
        .alu_result (alu_result),
        .rd_lo      (rd_lo),
        .rd_hi      (rd_hi),
        .busy       (busy),
        .z_valid    (z_valid),
        .bus_out    (bus_out),
        .bus_en     (bus_en)
`ifdef ZREG_FLAGS_EN
        ,
        .flag_z     (flag_z),
        .flag_n     (flag_n)
`endif
    );

    typedef struct packed {
        logic [63:0] z;
        logic [3:0]  n;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] cur_z;
    int          n_pass = 0;
    int          n_chk  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Entered and left at #1 after a rising edge.
    task automatic launch(input logic [4:0] op, input logic [63:0] res,
                          input logic [63:0] junk, input bit poke);
        int   n;
        exp_t e;
        n = (op == 5'b01111 || op == 5'b10000) ? 4 : 1;
        sb.push_back('{z: res, n: 4'(n)});
        op_select  = op;
        alu_result = junk;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            alu_result = (i == n - 1) ? res : junk;
            if (poke && i == 1) begin
                start     = 1'b1;
                op_select = 5'b00011;
            end
            @(negedge clk);
            chk("busy_settle", 64'(busy), 64'd1);
            chk("zv_settle", 64'(z_valid), 64'd0);
            @(posedge clk); #1;
            start = 1'b0;
        end
        alu_result = ~res;
        if (sb.size() == 0) begin
            chk("sb_empty", 64'(sb.size()), 64'd1);
        end else begin
            e     = sb.pop_front();
            cur_z = e.z;
            chk("zv_capture", 64'(z_valid), 64'd1);
            chk("busy_capture", 64'(busy), 64'd0);
        end
    endtask

    task automatic rd(input string tag, input bit lo, input bit hi,
                      input logic [31:0] exp_bus, input bit exp_en, input bit exp_zv);
        rd_lo = lo;
        rd_hi = hi;
        @(negedge clk);
        chk({tag, "_bus"}, 64'(bus_out), 64'(exp_bus));
        chk({tag, "_en"}, 64'(bus_en), 64'(exp_en));
        @(posedge clk); #1;
        rd_lo = 1'b0;
        rd_hi = 1'b0;
        chk({tag, "_zv"}, 64'(z_valid), 64'(exp_zv));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        start      = 1'($urandom);
        op_select  = 5'($urandom);
        alu_result = {$urandom, $urandom};
        rd_lo      = 1'($urandom);
        rd_hi      = 1'($urandom);
        @(posedge clk); #1;
        start = 1'($urandom);
        rd_lo = 1'b1;
        @(posedge clk); #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_zv", 64'(z_valid), 64'd0);
        chk("rst_en", 64'(bus_en), 64'd0);
        chk("rst_bus", 64'(bus_out), 64'd0);
        rst = 1'b0; start = 1'b0; rd_lo = 1'b0; rd_hi = 1'b0;
        @(posedge clk); #1;

        // add, fast path
        launch(5'b00011, 64'h5, 64'h0, 1'b0);
        rd("add_lo", 1'b1, 1'b0, cur_z[31:0], 1'b1, 1'b1);
        rd("add_hi", 1'b0, 1'b1, cur_z[63:32], 1'b1, 1'b0);
        rd("idle_rd", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);

        // mul, slow path with garbage until the last settle cycle
        launch(5'b01111, 64'h1_0000_0002, 64'hDEAD, 1'b0);
        rd("mul_hi", 1'b0, 1'b1, 32'h1, 1'b1, 1'b1);
        rd("mul_lo", 1'b1, 1'b0, 32'h2, 1'b1, 1'b0);

        // div with simultaneous read: lo wins, hi still pending
        launch(5'b10000, {32'd1, 32'd3}, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        rd("div_both", 1'b1, 1'b1, 32'd3, 1'b1, 1'b1);
        rd("div_lo2", 1'b1, 1'b0, 32'd3, 1'b1, 1'b1);
        rd("div_hi", 1'b0, 1'b1, 32'd1, 1'b1, 1'b0);

        // start during settle is ignored
        launch(5'b01111, 64'hCAFE_0000_1234_5678, 64'h0BAD, 1'b1);
        rd("poke_lo", 1'b1, 1'b0, 32'h1234_5678, 1'b1, 1'b1);
        rd("poke_hi", 1'b0, 1'b1, 32'hCAFE_0000, 1'b1, 1'b0);

        // restart from VALID abandons the unread half
        launch(5'b00001, 64'hAAAA_BBBB_CCCC_DDDD, 64'h0, 1'b0);
        rd("rs_lo", 1'b1, 1'b0, 32'hCCCC_DDDD, 1'b1, 1'b1);
        launch(5'b10000, 64'h0000_0007_0000_0009, 64'h1, 1'b0);
        rd("rs_hi", 1'b0, 1'b1, 32'h7, 1'b1, 1'b1);
        rd("rs_lo2", 1'b1, 1'b0, 32'h9, 1'b1, 1'b0);

        // unsupported opcode takes the fast path
        launch(5'b11111, 64'h0, 64'h0, 1'b0);
        rd("unsup_lo", 1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        rd("unsup_hi", 1'b0, 1'b1, 32'h0, 1'b1, 1'b0);

        // reset at settle cycle 2 discards the op
        sb.push_back('{z: 64'h1234, n: 4'd4});
        op_select = 5'b01111; alu_result = 64'h1234; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        void'(sb.pop_back());
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_zv", 64'(z_valid), 64'd0);
        for (int i = 0; i < 5; i++) begin
            rd("rst_mid_rd", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        end

`ifdef ZREG_FLAGS_EN
        launch(5'b00100, 64'h0000_0001_8000_0000, 64'h0, 1'b0);
        chk("flag_n_and", 64'(flag_n), 64'd1);
        chk("flag_z_and", 64'(flag_z), 64'd0);
        rd("fl_lo", 1'b1, 1'b0, 32'h8000_0000, 1'b1, 1'b1);
        rd("fl_hi", 1'b0, 1'b1, 32'h1, 1'b1, 1'b0);
        launch(5'b01111, 64'h0, 64'h8000_0000_0000_0001, 1'b0);
        chk("flag_z_mul", 64'(flag_z), 64'd1);
        chk("flag_n_mul", 64'(flag_n), 64'd0);
        rd("fl2_lo", 1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        rd("fl2_hi", 1'b0, 1'b1, 32'h0, 1'b1, 1'b0);
        chk("flag_z_hold", 64'(flag_z), 64'd1);
        launch(5'b10000, 64'h8000_0000_0000_0000, 64'h0, 1'b0);
        chk("flag_z_div", 64'(flag_z), 64'd0);
        chk("flag_n_div", 64'(flag_n), 64'd0);
`endif

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
